// File: rtl/wb_stream_pkg.sv
// Shared constants and helpers for the Wishbone stream ingress/egress paths.
// Sideband bit positions are common to both directions of the stream.
package wb_stream_pkg;

   localparam int WB_DW_DEF     = 32;
   localparam int STREAM_DW_DEF = 8;
   localparam int FIFO_AW_DEF   = 4;
   localparam int LANES_DEF     = WB_DW_DEF / STREAM_DW_DEF;

   // Stream sideband vector layout {last}
   localparam int SB_LAST_BIT = 0;
   localparam int SB_W        = 1;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 32; i++) begin
         if ((1 << r) < v) r++;
      end
      return r;
   endfunction

   // Keep the lane counter at least one bit wide when LANES==1
   function automatic int lane_w(input int lanes);
      return (lanes > 1) ? clog2(lanes) : 1;
   endfunction

endpackage

// File: rtl/wb_stream_fifo.sv
// First-word-fall-through word FIFO with count, synchronous clear and a
// sticky underflow flag.
module wb_stream_fifo #(
   parameter int DW = 32,
   parameter int AW = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clear,
   input  logic          push,
   input  logic [DW-1:0] wdata,
   input  logic          pop,
   output logic [DW-1:0] rdata,
   output logic [AW:0]   cnt,
   output logic          underflow
);

   localparam int DEPTH = 1 << AW;

   logic [DEPTH-1:0][DW-1:0] mem_q, mem_d;
   logic [AW-1:0]            wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]            rd_ptr_q, rd_ptr_d;
   logic [AW:0]              cnt_q, cnt_d;
   logic                     underflow_q, underflow_d;
   logic                     empty, full, pop_ok, push_ok;

   assign empty = (cnt_q == '0);
   assign full  = cnt_q[AW];
   assign pop_ok  = pop & ~empty;
   // A full FIFO only takes a word when the head leaves in the same cycle
   assign push_ok = push & (~full | pop_ok);

   always_comb begin
      mem_d       = mem_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      cnt_d       = cnt_q;
      underflow_d = underflow_q | (pop & empty);
      if (clear) begin
         wr_ptr_d    = '0;
         rd_ptr_d    = '0;
         cnt_d       = '0;
         underflow_d = 1'b0;
      end else begin
         if (push_ok) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + 1'b1;
         end
         if (pop_ok) rd_ptr_d = rd_ptr_q + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q       <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         cnt_q       <= '0;
         underflow_q <= 1'b0;
      end else begin
         mem_q       <= mem_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         cnt_q       <= cnt_d;
         underflow_q <= underflow_d;
      end
   end

   assign rdata     = mem_q[rd_ptr_q];
   assign cnt       = cnt_q;
   assign underflow = underflow_q;

endmodule

// File: rtl/wb_stream_reader_fifo.sv
// Stream ingress: packs narrow little-endian beats into bus words and
// buffers them in an FWFT FIFO drained by the stream-reader DMA.
module wb_stream_reader_fifo
   import wb_stream_pkg::*;
#(
   parameter int WB_DW     = WB_DW_DEF,
   parameter int STREAM_DW = STREAM_DW_DEF,
   parameter int FIFO_AW   = FIFO_AW_DEF
) (
   input  logic                 wb_clk_i,
   input  logic                 wb_rst_ni,
   input  logic [STREAM_DW-1:0] stream_s_data_i,
   input  logic                 stream_s_valid_i,
   input  logic                 stream_s_last_i,
   output logic                 stream_s_ready_o,
   output logic [WB_DW-1:0]     fifo_d,
   input  logic                 fifo_rd,
   output logic [FIFO_AW:0]     fifo_cnt,
   input  logic                 clear,
   output logic                 underflow
);

   localparam int LANES  = WB_DW / STREAM_DW;
   localparam int LANE_W = lane_w(LANES);
   localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);
   localparam logic [FIFO_AW:0]  DEPTH_CNT = {1'b1, {FIFO_AW{1'b0}}};

   logic [LANE_W-1:0] lane_q, lane_d;
   logic [WB_DW-1:0]  pack_q, pack_d;
   logic              rdy_en_q;
   logic [WB_DW-1:0]  word;
   logic [SB_W-1:0]   sb;
   logic              accept, complete;

   assign sb[SB_LAST_BIT] = stream_s_last_i;

   // rdy_en_q holds ready low through reset without a path from the reset pin
   assign stream_s_ready_o = rdy_en_q & (fifo_cnt != DEPTH_CNT) & ~clear;
   assign accept           = stream_s_valid_i & stream_s_ready_o;
   assign complete         = accept & ((lane_q == LAST_LANE) | sb[SB_LAST_BIT]);

   always_comb begin
      word = pack_q;
      word[lane_q*STREAM_DW +: STREAM_DW] = stream_s_data_i;
   end

   always_comb begin
      lane_d = lane_q;
      pack_d = pack_q;
      if (clear) begin
         lane_d = '0;
         pack_d = '0;
      end else if (complete) begin
         lane_d = '0;
         pack_d = '0;
      end else if (accept) begin
         lane_d = lane_q + 1'b1;
         pack_d = word;
      end
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         lane_q   <= '0;
         pack_q   <= '0;
         rdy_en_q <= 1'b0;
      end else begin
         lane_q   <= lane_d;
         pack_q   <= pack_d;
         rdy_en_q <= 1'b1;
      end
   end

   wb_stream_fifo #(
      .DW (WB_DW),
      .AW (FIFO_AW)
   ) u_fifo (
      .clk       (wb_clk_i),
      .rst_n     (wb_rst_ni),
      .clear     (clear),
      .push      (complete),
      .wdata     (word),
      .pop       (fifo_rd),
      .rdata     (fifo_d),
      .cnt       (fifo_cnt),
      .underflow (underflow)
   );

endmodule
